huffman_decoder: RTL and testbench

- Receive side of the Huffman path: loads the 6-entry code table (HC1..HC6 codes, M1..M6 masks) produced by the encoder when code_valid pulses.
- Accepts a serial MSB-first codeword bitstream and emits decoded gray symbols (8'd1..8'd6) through a valid/ready output handshake.
- Counts decoded symbols and flags undecodable bit sequences.

---
 rtl/huffman_decoder.sv | 152 +++++++++++++++
 tb/tb_huffman_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman codeword decoder with a 6-entry loadable code table.
// Emits symbol indices 1..6 over a valid/ready handshake and flags undecodable runs.
module huffman_decoder #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               code_valid,
  input  logic [MAX_LEN-1:0] HC1,
  input  logic [MAX_LEN-1:0] HC2,
  input  logic [MAX_LEN-1:0] HC3,
  input  logic [MAX_LEN-1:0] HC4,
  input  logic [MAX_LEN-1:0] HC5,
  input  logic [MAX_LEN-1:0] HC6,
  input  logic [MAX_LEN-1:0] M1,
  input  logic [MAX_LEN-1:0] M2,
  input  logic [MAX_LEN-1:0] M3,
  input  logic [MAX_LEN-1:0] M4,
  input  logic [MAX_LEN-1:0] M5,
  input  logic [MAX_LEN-1:0] M6,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               sym_valid,
  output logic [7:0]         sym_data,
  input  logic               sym_ready,
  output logic               err,
  output logic [CNT_W-1:0]   sym_count
);

  // state | meaning
  // EMPTY | no code table loaded, bits refused
  // RUN   | table loaded, decoding incoming bits
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [0:0]         r_state;
  logic [MAX_LEN-1:0] r_hc [6];
  logic [MAX_LEN-1:0] r_m  [6];
  logic [LW-1:0]      r_l  [6];
  logic [MAX_LEN-1:0] r_shreg;
  logic [LW-1:0]      r_len;
  logic               r_sym_valid;
  logic [7:0]         r_sym_data;
  logic               r_err;
  logic [CNT_W-1:0]   r_sym_count;

  logic [MAX_LEN-1:0] w_hc_in [6];
  logic [MAX_LEN-1:0] w_m_in  [6];
  logic [MAX_LEN-1:0] w_nshreg;
  logic [LW-1:0]      w_nlen;
  logic               w_bit_ready;
  logic               w_accept;
  logic               w_consume;
  logic               w_match;
  logic [2:0]         w_idx;

  function automatic logic [LW-1:0] f_popcount(input logic [MAX_LEN-1:0] m);
    logic [LW-1:0] c;
    c = '0;
    for (int k = 0; k < MAX_LEN; k++) c = c + LW'(m[k]);
    return c;
  endfunction

  assign w_hc_in[0] = HC1;
  assign w_hc_in[1] = HC2;
  assign w_hc_in[2] = HC3;
  assign w_hc_in[3] = HC4;
  assign w_hc_in[4] = HC5;
  assign w_hc_in[5] = HC6;
  assign w_m_in[0]  = M1;
  assign w_m_in[1]  = M2;
  assign w_m_in[2]  = M3;
  assign w_m_in[3]  = M4;
  assign w_m_in[4]  = M5;
  assign w_m_in[5]  = M6;

  // A stalled output symbol blocks new bits so no decoded symbol is ever dropped.
  assign w_bit_ready = (r_state == S_RUN) && !(r_sym_valid && !sym_ready);
  assign w_accept    = bit_valid && w_bit_ready;
  assign w_consume   = r_sym_valid && sym_ready;
  assign w_nshreg    = {r_shreg[MAX_LEN-2:0], bit_in};
  assign w_nlen      = r_len + LW'(1);

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    w_match = 1'b0;
    w_idx   = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (r_m[i] != '0 && w_nlen == r_l[i] && (w_nshreg & r_m[i]) == r_hc[i]) begin
        w_match = 1'b1;
        w_idx   = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_shreg     <= '0;
      r_len       <= '0;
      r_sym_valid <= 1'b0;
      r_sym_data  <= '0;
      r_err       <= 1'b0;
      r_sym_count <= '0;
      for (int i = 0; i < 6; i++) begin
        r_hc[i] <= '0;
        r_m[i]  <= '0;
        r_l[i]  <= '0;
      end
    end else begin
      r_err <= 1'b0;
      if (w_consume) begin
        r_sym_count <= r_sym_count + CNT_W'(1);
        r_sym_valid <= 1'b0;
      end
      if (code_valid) begin
        r_state <= S_RUN;
        r_shreg <= '0;
        r_len   <= '0;
        for (int i = 0; i < 6; i++) begin
          r_hc[i] <= w_hc_in[i];
          r_m[i]  <= w_m_in[i];
          r_l[i]  <= f_popcount(w_m_in[i]);
        end
      end else if (w_accept) begin
        if (w_match) begin
          r_sym_valid <= 1'b1;
          r_sym_data  <= 8'(w_idx);
          r_shreg     <= '0;
          r_len       <= '0;
        end else if (w_nlen == LW'(MAX_LEN)) begin
          r_err   <= 1'b1;
          r_shreg <= '0;
          r_len   <= '0;
        end else begin
          r_shreg <= w_nshreg;
          r_len   <= w_nlen;
        end
      end
    end
  end

  assign bit_ready = w_bit_ready;
  assign sym_valid = r_sym_valid;
  assign sym_data  = r_sym_data;
  assign err       = r_err;
  assign sym_count = r_sym_count;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a bit-queue reference model.
module tb_huffman_decoder;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               code_valid = 1'b0;
  logic [MAX_LEN-1:0] hc [6];
  logic [MAX_LEN-1:0] mk [6];
  logic               bit_valid = 1'b0;
  logic               bit_in = 1'b0;
  logic               bit_ready;
  logic               sym_valid;
  logic [7:0]         sym_data;
  logic               sym_ready = 1'b0;
  logic               err;
  logic [CNT_W-1:0]   sym_count;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // reference model: table as integers, pending codeword as a bit queue
  int         t_hc [6];
  int         t_m  [6];
  int         t_l  [6];
  bit         q [$];
  bit         m_loaded, m_valid, m_err, m_ready, m_cons;
  int         m_data, m_val, m_hit;
  logic [CNT_W-1:0] m_count;

  huffman_decoder #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(mk[0]), .M2(mk[1]), .M3(mk[2]), .M4(mk[3]), .M5(mk[4]), .M6(mk[5]),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .err(err), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_loaded = 0; m_valid = 0; m_data = 0; m_err = 0; m_count = '0;
      q.delete();
      for (int i = 0; i < 6; i++) begin t_hc[i] = 0; t_m[i] = 0; t_l[i] = 0; end
    end else begin
      m_ready = m_loaded && !(m_valid && !sym_ready);
      m_cons  = m_valid && sym_ready;
      m_err   = 0;
      if (m_cons) begin m_count = m_count + 1'b1; m_valid = 0; end
      if (code_valid) begin
        for (int i = 0; i < 6; i++) begin
          t_hc[i] = int'(hc[i]); t_m[i] = int'(mk[i]); t_l[i] = $countones(mk[i]);
        end
        m_loaded = 1;
        q.delete();
      end else if (bit_valid && m_ready) begin
        q.push_back(bit_in);
        m_val = 0;
        foreach (q[k]) m_val = m_val * 2 + int'(q[k]);
        m_hit = 0;
        for (int i = 0; i < 6; i++)
          if (m_hit == 0 && t_m[i] != 0 && t_l[i] == q.size() && m_val == t_hc[i]) m_hit = i + 1;
        if (m_hit != 0) begin
          m_valid = 1; m_data = m_hit; q.delete();
        end else if (q.size() == MAX_LEN) begin
          m_err = 1; q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model bit_ready", 32'(bit_ready), 32'(m_loaded && !(m_valid && !sym_ready)));
      chk("model sym_valid", 32'(sym_valid), 32'(m_valid));
      if (m_valid) chk("model sym_data", 32'(sym_data), 32'(m_data));
      chk("model err", 32'(err), 32'(m_err));
      chk("model sym_count", 32'(sym_count), 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_table(input bit use_m6);
    for (int i = 0; i < 5; i++) begin
      hc[i] = 8'h01;
      mk[i] = 8'((1 << (i + 1)) - 1);
    end
    hc[5] = 8'h00;
    mk[5] = use_m6 ? 8'h1F : 8'h00;
  endtask

  task automatic rand_table();
    int l;
    for (int i = 0; i < 6; i++) begin
      l = $urandom_range(0, MAX_LEN);
      mk[i] = 8'((1 << l) - 1);
      hc[i] = 8'($urandom) & mk[i];
    end
  endtask

  task automatic load(input bit use_m6);
    set_table(use_m6);
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  int b1 [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
  int v1 [8] = '{1, 0, 1, 0, 0, 0, 0, 1};
  int d1 [8] = '{1, 0, 2, 0, 0, 0, 0, 6};

  initial begin
    set_table(1'b1);
    reset = 1'b0;
    repeat (3) tick();
    chk("reset bit_ready", 32'(bit_ready), 0);
    chk("reset sym_valid", 32'(sym_valid), 0);
    chk("reset sym_count", 32'(sym_count), 0);
    reset = 1'b1;
    chk_en = 1'b1;
    tick();

    // mixed-length stream: 1 | 01 | 00000
    load(1'b1);
    sym_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bit_valid = 1'b1; bit_in = b1[k];
      tick();
      chk("stream sym_valid", 32'(sym_valid), 32'(v1[k]));
      if (v1[k] != 0) chk("stream sym_data", 32'(sym_data), 32'(d1[k]));
    end
    bit_valid = 1'b0;
    tick();
    chk("stream count", 32'(sym_count), 3);

    // back-to-back 1-bit codes
    for (int k = 0; k < 3; k++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      chk("b2b sym_valid", 32'(sym_valid), 1);
      chk("b2b sym_data", 32'(sym_data), 1);
    end
    bit_valid = 1'b0;
    tick();
    chk("b2b count", 32'(sym_count), 6);

    // backpressure
    sym_ready = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    chk("bp sym_valid", 32'(sym_valid), 1);
    bit_in = 1'b0;
    #1 chk("bp bit_ready low", 32'(bit_ready), 0);
    tick();
    chk("bp held data", 32'(sym_data), 1);
    chk("bp held count", 32'(sym_count), 6);
    sym_ready = 1'b1;
    #1 chk("bp bit_ready back", 32'(bit_ready), 1);
    tick();
    chk("bp consumed", 32'(sym_count), 7);
    bit_in = 1'b1;
    tick();
    chk("bp resume data", 32'(sym_data), 2);
    chk("bp resume valid", 32'(sym_valid), 1);
    bit_valid = 1'b0;
    tick();
    chk("bp count", 32'(sym_count), 8);

    // undecodable run of zeros with M6 unused
    load(1'b0);
    for (int k = 0; k < 8; k++) begin
      bit_valid = 1'b1; bit_in = 1'b0;
      tick();
      chk("err pulse", 32'(err), (k == 7) ? 1 : 0);
      chk("err no sym", 32'(sym_valid), 0);
    end
    bit_in = 1'b1;
    tick();
    chk("err cleared", 32'(err), 0);
    chk("after err data", 32'(sym_data), 1);
    bit_valid = 1'b0;
    tick();

    // reload flushes a partial codeword and drops the same-cycle bit
    load(1'b1);
    bit_valid = 1'b1; bit_in = 1'b0;
    tick(); tick();
    set_table(1'b1);
    code_valid = 1'b1; bit_in = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    chk("flush sym_valid", 32'(sym_valid), 1);
    chk("flush sym_data", 32'(sym_data), 1);
    chk("flush err", 32'(err), 0);

    // asynchronous reset mid-stream
    #2 reset = 1'b0;
    #1;
    chk("async sym_valid", 32'(sym_valid), 0);
    chk("async sym_data", 32'(sym_data), 0);
    chk("async bit_ready", 32'(bit_ready), 0);
    chk("async sym_count", 32'(sym_count), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post reset bit_ready", 32'(bit_ready), 0);
    bit_valid = 1'b0;

    // randomized run
    rand_table();
    code_valid = 1'b1;
    tick();
    for (int n = 0; n < 3000; n++) begin
      code_valid = ($urandom_range(0, 39) == 0);
      if (code_valid) begin
        if ($urandom_range(0, 2) == 0) set_table($urandom_range(0, 1) == 1);
        else rand_table();
      end
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_in    = 1'($urandom);
      sym_ready = ($urandom_range(0, 2) != 0);
      if (n == 1500) begin
        #2 reset = 1'b0;
        #1 chk("rand async count", 32'(sym_count), 0);
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end
    bit_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
